// File: rtl/mem_copy_defs.sv
// Shared definitions for the memory copy engine: FSM state encodings and default widths.
package mem_copy_defs;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/copy_addr_gen.sv
// Read/write pointer and remaining-count generator for the copy engine.
// Loads start pointers for the chosen direction, then steps once per copied word.
module copy_addr_gen
  import mem_copy_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_dir,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic [ADDR_WIDTH-1:0] o_rd_ptr,
  output logic [ADDR_WIDTH-1:0] o_wr_ptr,
  output logic                  o_last
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_desc;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH-1:0] w_span;

  assign w_len  = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  // Offset of the last word; address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign w_span = ADDR_WIDTH'(w_len - (ADDR_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_desc      <= 1'b0;
    end else if (i_load) begin
      r_desc      <= i_dir;
      r_rd_ptr    <= i_dir ? i_src + w_span : i_src;
      r_wr_ptr    <= i_dir ? i_dst + w_span : i_dst;
      r_remaining <= w_len;
    end else if (i_step) begin
      r_rd_ptr    <= r_desc ? r_rd_ptr - ADDR_WIDTH'(1) : r_rd_ptr + ADDR_WIDTH'(1);
      r_wr_ptr    <= r_desc ? r_wr_ptr - ADDR_WIDTH'(1) : r_wr_ptr + ADDR_WIDTH'(1);
      r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
    end
  end

  assign o_rd_ptr = r_rd_ptr;
  assign o_wr_ptr = r_wr_ptr;
  assign o_last   = (r_remaining == (ADDR_WIDTH+1)'(1));

endmodule

// File: rtl/mem_copy_engine.sv
// memmove-safe word copier driving a single-port memory with one-cycle registered read.
// Alternates READ/WRITE per word; direction chosen so overlapping ranges copy correctly.
module mem_copy_engine
  import mem_copy_defs::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic                  w_last;
  logic                  w_load;
  logic                  w_step;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_WRITE);

  copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_dir    (dst > src),
    .i_src    (src),
    .i_dst    (dst),
    .i_len    (len),
    .o_rd_ptr (w_rd_ptr),
    .o_wr_ptr (w_wr_ptr),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr_hold <= '0;
      r_data_hold <= '0;
    end else begin
      r_state     <= w_next;
      r_addr_hold <= mem_addr;
      r_data_hold <= mem_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_READ;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address/data hold their last driven value outside READ/WRITE.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = r_addr_hold;
    mem_data = r_data_hold;
    case (r_state)
      S_READ: begin
        busy     = 1'b1;
        mem_addr = w_rd_ptr;
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = w_wr_ptr;
        mem_data = mem_out;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory, word-sequential reference model, directed + random copies.
module tb_mem_copy_engine;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_out;

  logic [DW-1:0] tb_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          mem_init;
  int            we_cnt, done_cnt;
  int            n_vec, n_err;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_out(mem_out)
  );

  // Single-port synchronous memory with registered read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 16'h1000 + 16'(i);
      mem_out <= '0;
    end else begin
      if (mem_we) tb_mem[mem_addr] <= mem_data;
      mem_out <= tb_mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: copy word by word in the engine's chosen direction, modulo DEPTH.
  task automatic ref_copy(input int s, input int d, input int l, input int max_words);
    int  L;
    bit  desc;
    int  ra, wa;
    L = (l > DEPTH) ? DEPTH : l;
    desc = d > s;
    for (int k = 0; k < L && k < max_words; k++) begin
      ra = desc ? (s + L - 1 - k) % DEPTH : (s + k) % DEPTH;
      wa = desc ? (d + L - 1 - k) % DEPTH : (d + k) % DEPTH;
      ref_mem[wa] = ref_mem[ra];
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("%s_mem%0d", tag, i), 32'(tb_mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic run_copy(input string tag, input int s, input int d, input int l, input bit mid_start);
    int L, n, we0, dn0, last_wa;
    bit busy_bad;
    L = (l > DEPTH) ? DEPTH : l;
    @(negedge clk);
    we0 = we_cnt; dn0 = done_cnt;
    start = 1'b1; src = AW'(s); dst = AW'(d); len = (AW+1)'(l);
    @(negedge clk);
    start = 1'b0;
    n = 1; busy_bad = 0;
    while (done !== 1'b1 && n < 400) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (mid_start && n == 3) begin
        start = 1'b1; src = 6'd1; dst = 6'd30; len = 7'd5;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_cycle"}, 32'(n), 32'((L == 0) ? 1 : 2 * L + 1));
    chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (mid_start) begin
      start = 1'b1; src = 6'd2; dst = 6'd33; len = 7'd4;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_we_count"}, 32'(we_cnt - we0), 32'(L));
    chk({tag, "_done_count"}, 32'(done_cnt - dn0), 32'd1);
    if (L > 0) begin
      last_wa = (d > s) ? d : (d + L - 1) % DEPTH;
      chk({tag, "_addr_hold"}, 32'(mem_addr), 32'(last_wa));
    end
    ref_copy(s, d, l, DEPTH);
    chk_mem(tag);
  endtask

  initial begin
    int s, d, l;
    n_vec = 0; n_err = 0;
    we_cnt = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    mem_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h1000 + 16'(i);
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0; done_cnt = 0;

    run_copy("basic", 4, 40, 3, 1'b0);
    run_copy("ovl_desc", 10, 12, 4, 1'b0);
    run_copy("ovl_asc", 12, 10, 4, 1'b0);
    run_copy("wrap_src", 62, 20, 4, 1'b0);
    run_copy("wrap_dst", 30, 62, 4, 1'b0);
    run_copy("zero_len", 7, 50, 0, 1'b0);
    run_copy("same", 9, 9, 5, 1'b0);
    run_copy("mid_start", 20, 45, 3, 1'b1);
    run_copy("clamp", 5, 7, 100, 1'b0);

    // Reset during the second READ of a 3-word ascending copy
    @(negedge clk);
    start = 1'b1; src = 6'd50; dst = 6'd20; len = 7'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    ref_copy(50, 20, 3, 1);
    repeat (2) @(negedge clk);
    chk_mem("rstmid");
    run_copy("after_rst", 33, 3, 6, 1'b0);

    for (int it = 0; it < 8; it++) begin
      s = int'($urandom_range(0, DEPTH - 1));
      d = int'($urandom_range(0, DEPTH - 1));
      l = int'($urandom_range(0, 70));
      run_copy($sformatf("rand%0d", it), s, d, l, it[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
